updown_load_counter: RTL and testbench
======================================

Name: updown_load_counter

Overview:
- Loadable, bounded up/down counter. It is the design under test that sits behind counter_if: it consumes data_in/load/mode from the write driver and produces data_out for the read monitor.
- Counts within 0..MAX_VAL, wraps at the bounds and flags terminal count.
- Clamps out-of-range load values and flags them.
- Tracks its operating phase in a small state machine so the scoreboard can check direction changes.

Parameters:
- WIDTH, 4, width of data_in/data_out and of the count register.
- MAX_VAL, 11, upper count bound; legal range 1..(2**WIDTH)-1.

Ports:
- clock     input   1      system clock, all state updates on its rising edge
- reset_n   input   1      asynchronous, active-low reset
- data_in   input   WIDTH  load value
- load      input   1      synchronous load strobe
- mode      input   1      count direction: 1 = up, 0 = down
- enable    input   1      count enable; 0 = hold (does not gate load)
- data_out  output  WIDTH  registered count value
- tc        output  1      terminal-count pulse, high for one cycle on a wrap/bound hit
- load_err  output  1      high for one cycle when a load value exceeded MAX_VAL
- state_o   output  2      FSM state: 00 IDLE, 01 UP, 10 DOWN, 11 TURN

Behaviour:
- Reset: reset_n=0 asynchronously forces data_out=0, tc=0, load_err=0, state=IDLE, independent of clock. Release takes effect at the first rising edge with reset_n=1.
- Assertion of reset_n mid-count aborts immediately; no partial update survives.
- Per-edge priority: load > count > hold.
- Load (load=1):
  - If data_in<=MAX_VAL: data_out<=data_in.
  - Else: data_out<=MAX_VAL and load_err<=1 for that cycle.
  - tc<=0.
  - FSM enters UP or DOWN per mode; TURN is skipped.
- Count (load=0, enable=1):
  - mode=1: data_out+1; at MAX_VAL wrap to 0 with tc<=1.
  - mode=0: data_out-1; at 0 wrap to MAX_VAL with tc<=1.
- Hold (load=0, enable=0): data_out, state unchanged; tc<=0, load_err<=0.
- Latency: data_out reflects a load/count on the same rising edge where it was sampled, i.e. visible 1 cycle after inputs are presented. This matches the monitor sampling at the following edge.
- FSM:
  - IDLE -> UP/DOWN on the first load, or the first enable=1 (by mode). IDLE with enable=1 counts on that same edge.
  - UP <-> DOWN: a mode change while enable=1 and load=0 moves to TURN for exactly one cycle. data_out holds and tc=0 during TURN.
  - TURN -> the new direction's state next cycle, counting resumes.
  - A mode change in TURN re-enters TURN.
  - A mode change with enable=0 is registered without TURN when enable rises; the first enabled cycle then goes through TURN.
  - Load from any state cancels TURN.
- Arithmetic: WIDTH-bit unsigned. Values above MAX_VAL are never held in the count register.
- tc and load_err are registered single-cycle pulses and never both high. A clamped load also forces tc=0.

Optional Feature:
- Macro: COUNTER_SAT_MODE_EN.
- Defined:
  - Counting saturates: up at MAX_VAL holds MAX_VAL, down at 0 holds 0.
  - tc is asserted every cycle the counter is pinned at a bound while enable=1.
  - Load, TURN and clamping are unchanged.
- Undefined: wrap-around behaviour as above; tc is a single pulse per wrap.

Test Plan:
- Reset mid-count:
  - Stimulus: load 5, up for 3 cycles (data_out=8), then drop reset_n between edges.
  - Required: data_out=0, state=IDLE, tc=0 immediately without a clock edge. After release, enable=1 mode=1 gives data_out=1.
- Up wrap:
  - Stimulus: load 10, mode=1, enable=1.
  - Required: sequence 10,11,0,1; tc=1 only on the cycle data_out becomes 0.
  - With COUNTER_SAT_MODE_EN: sequence 10,11,11,11 with tc=1 while pinned.
- Down wrap:
  - Stimulus: load 1, mode=0.
  - Required: sequence 1,0,11,10; tc=1 on the cycle data_out becomes 11.
- Clamped load:
  - Stimulus: load with data_in=14.
  - Required: data_out=11, load_err=1 for one cycle, tc=0.
  - A following load of 3 gives load_err=0, data_out=3.
- Direction turn:
  - Stimulus: counting up at 4, flip mode to 0.
  - Required: state 01 -> 11 for one cycle with data_out held at 5, then 10 with data_out=4,3.
- Load priority:
  - Stimulus: load=1, enable=1, mode=1, data_in=7 while in TURN.
  - Required: data_out=7, state=UP next cycle, no TURN cycle.
  - With enable=0 and load=0: data_out holds for 4 cycles, tc stays 0.

Source files
------------

// File: rtl/updown_load_counter_if.sv
// updown_load_counter_if: load/count bus between the write driver, the counter and the read monitor.
interface updown_load_counter_if #(parameter int WIDTH = 4);
    logic [WIDTH-1:0] data_in;
    logic             load;
    logic             mode;
    logic             enable;
    logic [WIDTH-1:0] data_out;
    logic             tc;
    logic             load_err;
    logic [1:0]       state_o;
    modport master (output data_in, load, mode, enable, input data_out, tc, load_err, state_o);
    modport slave (input data_in, load, mode, enable, output data_out, tc, load_err, state_o);
endinterface

// File: rtl/updown_load_counter.sv
// updown_load_counter: bounded loadable up/down counter with clamped loads and a direction-turn FSM.
// Define COUNTER_SAT_MODE_EN to saturate at the bounds instead of wrapping.
module updown_load_counter #(
    parameter int WIDTH   = 4,
    parameter int MAX_VAL = 11
) (
    input logic                 clock,
    input logic                 reset_n,
    updown_load_counter_if.slave bus
);
    typedef enum logic [1:0] {IDLE = 2'b00, UP = 2'b01, DOWN = 2'b10, TURN = 2'b11} state_t;
    localparam logic [WIDTH-1:0] MAX = MAX_VAL[WIDTH-1:0];
    state_t           state, state_nx;
    logic             dir, dir_nx;
    logic [WIDTH-1:0] cnt, cnt_nx, up_v, dn_v;
    logic             tc_q, tc_nx, err_q, err_nx, at_top, at_bot, over;
    assign at_top = cnt == MAX;
    assign at_bot = cnt == '0;
    assign over   = bus.data_in > MAX;
`ifdef COUNTER_SAT_MODE_EN
    assign up_v = at_top ? MAX : cnt + 1'b1;
    assign dn_v = at_bot ? '0 : cnt - 1'b1;
`else
    assign up_v = at_top ? '0 : cnt + 1'b1;
    assign dn_v = at_bot ? MAX : cnt - 1'b1;
`endif
    // dir holds the committed direction; in TURN it is the direction being turned to
    always_comb begin
        state_nx = state;
        dir_nx   = dir;
        cnt_nx   = cnt;
        tc_nx    = 1'b0;
        err_nx   = 1'b0;
        if (bus.load) begin
            cnt_nx   = over ? MAX : bus.data_in;
            err_nx   = over;
            state_nx = bus.mode ? UP : DOWN;
            dir_nx   = bus.mode;
        end else if (bus.enable) begin
            dir_nx = bus.mode;
            if (state != IDLE && bus.mode != dir) begin
                state_nx = TURN;
            end else begin
                state_nx = bus.mode ? UP : DOWN;
                cnt_nx   = bus.mode ? up_v : dn_v;
                tc_nx    = bus.mode ? at_top : at_bot;
            end
        end
    end
    always_ff @(posedge clock or negedge reset_n) begin
        if (!reset_n) begin
            state <= IDLE;
            dir   <= 1'b0;
            cnt   <= '0;
            tc_q  <= 1'b0;
            err_q <= 1'b0;
        end else begin
            state <= state_nx;
            dir   <= dir_nx;
            cnt   <= cnt_nx;
            tc_q  <= tc_nx;
            err_q <= err_nx;
        end
    end
    assign bus.data_out = cnt;
    assign bus.tc       = tc_q;
    assign bus.load_err = err_q;
    assign bus.state_o  = state;
endmodule

// File: tb/tb_updown_load_counter.sv
// tb_updown_load_counter: directed and random stimulus checked against an arithmetic reference model.
module tb_updown_load_counter;
    localparam int W  = 4;
    localparam int MX = 11;
    logic clock   = 1'b0;
    logic reset_n = 1'b0;
    always #5 clock = ~clock;
    updown_load_counter_if #(.WIDTH(W)) bus ();
    updown_load_counter #(.WIDTH(W), .MAX_VAL(MX)) dut (.clock(clock), .reset_n(reset_n), .bus(bus));
    int tests = 0;
    int fails = 0;
    // phase: 0 idle, 1 up, 2 down, 3 turn; m_dir is the direction being counted or turned to
    int m_cnt, m_ph, m_dir, m_tc, m_err;
    task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] exp);
        tests++;
        assert (obs === exp) else begin
            fails++;
            $error("FAIL %s: got %0d expected %0d", tag, obs, exp);
        end
    endtask
    task automatic model_reset();
        m_cnt = 0; m_ph = 0; m_dir = 0; m_tc = 0; m_err = 0;
    endtask
    task automatic model_edge(input int ld, input int md, input int en, input int din);
        int hit;
        m_tc  = 0;
        m_err = 0;
        if (ld != 0) begin
            m_err = (din > MX) ? 1 : 0;
            m_cnt = m_err ? MX : din;
            m_ph  = md ? 1 : 2;
            m_dir = md;
        end else if (en != 0) begin
            if (m_ph != 0 && md != m_dir) begin
                m_ph  = 3;
                m_dir = md;
            end else begin
                m_ph  = md ? 1 : 2;
                m_dir = md;
                hit   = md ? int'(m_cnt == MX) : int'(m_cnt == 0);
                m_tc  = hit;
`ifdef COUNTER_SAT_MODE_EN
                if (hit == 0) m_cnt = md ? m_cnt + 1 : m_cnt - 1;
`else
                m_cnt = md ? (m_cnt + 1) % (MX + 1) : (m_cnt + MX) % (MX + 1);
`endif
            end
        end
    endtask
    task automatic check_all(input string tag);
        chk({tag, ".data_out"}, bus.data_out, m_cnt);
        chk({tag, ".tc"}, bus.tc, m_tc);
        chk({tag, ".load_err"}, bus.load_err, m_err);
        chk({tag, ".state"}, bus.state_o, m_ph);
        chk({tag, ".tc_and_err"}, bus.tc & bus.load_err, 0);
    endtask
    task automatic step(input string tag, input logic ld, input logic md, input logic en, input logic [W-1:0] din);
        bus.load    = ld;
        bus.mode    = md;
        bus.enable  = en;
        bus.data_in = din;
        @(posedge clock);
        model_edge(int'(ld), int'(md), int'(en), int'(din));
        #1;
        check_all(tag);
    endtask
    initial begin
        logic md;
        bus.load = 1'b0; bus.mode = 1'b0; bus.enable = 1'b0; bus.data_in = '0;
        model_reset();
        #12;
        check_all("reset");
        reset_n = 1'b1;
        step("ld5", 1, 1, 1, 5);
        repeat (3) step("up", 0, 1, 1, 0);
        chk("pre_rst", bus.data_out, 8);
        #2 reset_n = 1'b0;
        #1;
        model_reset();
        check_all("async_rst");
        chk("async_rst.const", {bus.data_out, bus.state_o, bus.tc}, 0);
        #1 reset_n = 1'b1;
        step("post_rst", 0, 1, 1, 0);
        chk("post_rst.const", bus.data_out, 1);
        step("ld10", 1, 1, 1, 10);
        repeat (3) step("upwrap", 0, 1, 1, 0);
        step("ld1", 1, 0, 1, 1);
        repeat (3) step("dnwrap", 0, 0, 1, 0);
        step("clamp", 1, 1, 0, 14);
        chk("clamp.const", {bus.data_out, bus.load_err, bus.tc}, {4'd11, 1'b1, 1'b0});
        step("ld3", 1, 1, 0, 3);
        chk("ld3.const", {bus.data_out, bus.load_err}, {4'd3, 1'b0});
        step("ld4", 1, 1, 1, 4);
        step("up5", 0, 1, 1, 0);
        step("turn", 0, 0, 1, 0);
        chk("turn.const", {bus.state_o, bus.data_out}, {2'b11, 4'd5});
        step("dn4", 0, 0, 1, 0);
        chk("dn4.const", {bus.state_o, bus.data_out}, {2'b10, 4'd4});
        step("dn3", 0, 0, 1, 0);
        chk("dn3.const", bus.data_out, 3);
        step("turn2", 0, 1, 1, 0);
        step("ld_turn", 1, 1, 1, 7);
        chk("ld_turn.const", {bus.state_o, bus.data_out}, {2'b01, 4'd7});
        repeat (4) step("hold", 0, 1, 0, 0);
        chk("hold.const", {bus.data_out, bus.tc}, {4'd7, 1'b0});
        repeat (2) step("flip_idle", 0, 0, 0, 0);
        step("late_turn", 0, 0, 1, 0);
        chk("late_turn.const", bus.state_o, 3);
        step("return", 0, 1, 1, 0);
        chk("return.const", bus.state_o, 3);
        step("resume", 0, 1, 1, 0);
        chk("resume.const", {bus.state_o, bus.data_out}, {2'b01, 4'd8});
        md = 1'b1;
        for (int i = 0; i < 400; i++) begin
            if ($urandom_range(3) == 0) md = ~md;
            step("rand", $urandom_range(5) == 0, md, $urandom_range(3) != 0, W'($urandom_range(15)));
        end
        $display("[TB] %0d tests run, %0d failed", tests, fails);
        $finish;
    end
endmodule
